// File: rtl/reg_alu_seq.sv
// reg_alu_seq: expands ALU/LOAD instructions into read/execute/write-back datapath controls.
// Optional SEQ_OVF_TRAP_EN: suppress write-back of overflowing ALU results and pulse ovf_trap.
module reg_alu_seq #(
  parameter int ADSize  = 5,
  parameter int DASize  = 32,
  parameter int OPSize  = 3,
  parameter int CNTSize = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_kind,
  input  logic [OPSize-1:0]  in_op,
  input  logic [ADSize-1:0]  in_rd,
  input  logic [ADSize-1:0]  in_rs1,
  input  logic [ADSize-1:0]  in_rs2,
  input  logic [DASize-1:0]  in_imm,
  output logic               Write,
  output logic               Read,
  output logic               S,
  output logic [ADSize-1:0]  Write_ADDR,
  output logic [ADSize-1:0]  Read_ADDR_1,
  output logic [ADSize-1:0]  Read_ADDR_2,
  output logic [OPSize-1:0]  OP,
  output logic [DASize-1:0]  DIN,
  input  logic               Overflow,
  output logic               done,
  output logic               ovf_sticky,
  output logic [CNTSize-1:0] retired
`ifdef SEQ_OVF_TRAP_EN
  ,
  output logic               ovf_trap
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;
  logic [1:0]         r_state;
  logic               r_kind;
  logic [OPSize-1:0]  r_op;
  logic [ADSize-1:0]  r_rd;
  logic [ADSize-1:0]  r_rs1;
  logic [ADSize-1:0]  r_rs2;
  logic [DASize-1:0]  r_imm;
  logic               r_sticky;
  logic [CNTSize-1:0] r_retired;
  logic               w_acc;
  logic               w_wb;
  logic               w_trap;
  logic [1:0]         w_next;
  assign w_acc = in_valid && r_state == IDLE;
  assign w_wb  = r_state == WB;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_acc ? (in_kind ? WB : READ) : IDLE) :
             (r_state == READ) ? EXEC :
             (r_state == EXEC) ? WB : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_kind    <= 1'b0;
      r_op      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_sticky  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_kind <= in_kind;
        r_op   <= in_op;
        r_rd   <= in_rd;
        r_rs1  <= in_rs1;
        r_rs2  <= in_rs2;
        r_imm  <= in_imm;
      end
      if (r_state == EXEC && Overflow) r_sticky <= 1'b1;
      if (w_wb) r_retired <= r_retired + CNTSize'(1);
    end
  end
`ifdef SEQ_OVF_TRAP_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst || w_acc) r_ovf <= 1'b0;
    else if (r_state == EXEC) r_ovf <= Overflow;
  end
  assign w_trap   = w_wb && !r_kind && r_ovf;
  assign ovf_trap = w_trap;
`else
  assign w_trap = 1'b0;
`endif
  assign in_ready    = r_state == IDLE;
  assign Write       = w_wb && !w_trap;
  // ALU write-back keeps Read asserted so the ALU result stays stable while written
  assign Read        = r_state == READ || r_state == EXEC || (w_wb && !r_kind);
  assign S           = w_wb && !r_kind;
  assign Write_ADDR  = r_rd;
  assign Read_ADDR_1 = r_rs1;
  assign Read_ADDR_2 = r_rs2;
  assign OP          = r_op;
  assign DIN         = r_imm;
  assign done        = w_wb;
  assign ovf_sticky  = r_sticky;
  assign retired     = r_retired;
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed stimulus with a write-back scoreboard for reg_alu_seq (CNTSize=4).
module tb_reg_alu_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_kind, Overflow;
  logic        in_ready, Write, Read, S, done, ovf_sticky;
  logic [2:0]  in_op, OP;
  logic [4:0]  in_rd, in_rs1, in_rs2, Write_ADDR, Read_ADDR_1, Read_ADDR_2;
  logic [31:0] in_imm, DIN;
  logic [3:0]  retired;
`ifdef SEQ_OVF_TRAP_EN
  logic        ovf_trap;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int m_ret = 0;
  logic m_sticky = 1'b0;
  typedef struct {
    logic        k;
    logic        wr;
    logic        trap;
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    int          ret;
  } exp_t;
  exp_t m_q[$];
  exp_t e;
  reg_alu_seq #(.CNTSize(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .Write(Write), .Read(Read), .S(S), .Write_ADDR(Write_ADDR), .Read_ADDR_1(Read_ADDR_1),
    .Read_ADDR_2(Read_ADDR_2), .OP(OP), .DIN(DIN), .Overflow(Overflow), .done(done),
    .ovf_sticky(ovf_sticky), .retired(retired)
`ifdef SEQ_OVF_TRAP_EN
    , .ovf_trap(ovf_trap)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("stray_write", 32'(Write & ~done), 0);
    if (done) begin
      if (m_q.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin
        e = m_q.pop_front();
        chk("wb_write", 32'(Write), 32'(e.wr));
        chk("wb_s", 32'(S), 32'(!e.k));
        chk("wb_read", 32'(Read), 32'(!e.k));
        chk("wb_waddr", 32'(Write_ADDR), 32'(e.rd));
        chk("wb_retired", 32'(retired), e.ret);
        chk("wb_ready", 32'(in_ready), 0);
        if (e.k) chk("wb_din", DIN, e.imm);
        else begin
          chk("wb_raddr1", 32'(Read_ADDR_1), 32'(e.rs1));
          chk("wb_raddr2", 32'(Read_ADDR_2), 32'(e.rs2));
          chk("wb_op", 32'(OP), 32'(e.op));
        end
`ifdef SEQ_OVF_TRAP_EN
        chk("wb_trap", 32'(ovf_trap), 32'(e.trap));
`endif
      end
    end
  end
  task automatic chk_reset();
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_ctl", {29'd0, Write, Read, S}, 0);
    chk("rst_addr", {17'd0, Write_ADDR, Read_ADDR_1, Read_ADDR_2}, 0);
    chk("rst_op", 32'(OP), 0);
    chk("rst_din", DIN, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    chk("rst_retired", 32'(retired), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_q.delete();
    m_ret = 0;
    m_sticky = 1'b0;
    @(negedge clk);
  endtask
  task automatic issue(input logic k, input logic [2:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [31:0] imm, input logic ovf, noise, hold);
    exp_t x;
    int w = 0;
    in_kind = k; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(in_ready), 1);
    x.k = k; x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.imm = imm; x.ret = m_ret;
`ifdef SEQ_OVF_TRAP_EN
    x.wr = k | ~ovf;
    x.trap = ~k & ovf;
`else
    x.wr = 1'b1;
    x.trap = 1'b0;
`endif
    m_q.push_back(x);
    m_ret = (m_ret + 1) % 16;
    if (!k && ovf) m_sticky = 1'b1;
    @(posedge clk);
    #1 if (!hold) in_valid = 1'b0;
    if (k) begin
      @(negedge clk);
      @(posedge clk);
    end else begin
      Overflow = noise;
      @(negedge clk);
      chk("read_ready", 32'(in_ready), 0);
      chk("read_read", 32'(Read), 1);
      @(posedge clk);
      #1 Overflow = ovf;
      @(negedge clk);
      chk("exec_read", 32'(Read), 1);
      chk("exec_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1 Overflow = noise;
      @(negedge clk);
      @(posedge clk);
      #1 Overflow = 1'b0;
    end
    @(negedge clk);
    chk("ready_back", 32'(in_ready), 1);
    chk("retired", 32'(retired), m_ret);
    chk("sticky", 32'(ovf_sticky), 32'(m_sticky));
  endtask
  initial begin
    in_valid = 0; in_kind = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    Overflow = 0;
    do_reset();
    chk_reset();
    issue(1, 3'd0, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 0, 0, 0);
    chk("load_retired", 32'(retired), 1);
    issue(0, 3'd0, 5'd5, 5'd3, 5'd4, 32'h0, 0, 0, 0);
    issue(0, 3'd1, 5'd6, 5'd1, 5'd2, 32'h0, 0, 1, 0);
    chk("noise_sticky", 32'(ovf_sticky), 0);
    issue(0, 3'd0, 5'd9, 5'd7, 5'd8, 32'h0, 1, 0, 0);
    issue(0, 3'd2, 5'd10, 5'd11, 5'd12, 32'h0, 0, 0, 0);
    chk("sticky_held", 32'(ovf_sticky), 1);
    issue(1, 3'd0, 5'd0, 5'd0, 5'd0, 32'h12345678, 0, 0, 0);
    in_kind = 0; in_op = 3'd4; in_rd = 5'd17; in_rs1 = 5'd18; in_rs2 = 5'd19; in_imm = 32'h55;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_q.delete();
    m_ret = 0;
    m_sticky = 1'b0;
    @(negedge clk);
    chk_reset();
    for (int i = 0; i < 10; i++)
      issue(i[0], 3'(i), 5'(i + 10), 5'(i), 5'(i + 1), 32'hA0000000 + i, i == 4, 0, 1);
    in_valid = 1'b0;
    chk("cont_retired", 32'(retired), 10);
    do_reset();
    for (int i = 0; i < 17; i++) issue(1, 3'd0, 5'(i), 5'd0, 5'd0, 32'(i * 3), 0, 0, 0);
    chk("wrap_retired", 32'(retired), 1);
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(m_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_alu_seq.md
# reg_alu_seq

Micro-sequencer driving the control side of the register-file/ALU datapath. Accepts one instruction per valid/ready handshake and expands it into the multi-cycle read/execute/write-back control sequence that the datapath consumes. These signals are Write, Read, S, the three addresses, OP and DIN. Sits between the instruction source (test driver or fetch stage) and the datapath; reports completion, overflow and a retired-instruction count.

## Interface
- ADSize, 5, register address width
- DASize, 32, data width
- OPSize, 3, ALU opcode width
- CNTSize, 16, retired-instruction counter width

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction offered
- in_ready  output  1  sequencer can accept; high only in IDLE
- in_kind  input  1  0 = ALU op (rd <- rs1 OP rs2), 1 = LOAD (rd <- in_imm)
- in_op  input  OPSize  ALU opcode
- in_rd, in_rs1, in_rs2  input  ADSize  destination / source addresses
- in_imm  input  DASize  load immediate
- Write, Read, S  output  1  datapath controls (S=0 selects DIN, S=1 selects ALU result)
- Write_ADDR, Read_ADDR_1, Read_ADDR_2  output  ADSize  datapath addresses
- OP  output  OPSize  datapath opcode
- DIN  output  DASize  datapath external write data
- Overflow  input  1  datapath ALU overflow, sampled in EXEC
- done  output  1  one-cycle pulse on write-back cycle (or suppressed write, see Configuration)
- ovf_sticky  output  1  set when any executed ALU op overflowed; cleared only by rst
- retired  output  CNTSize  count of completed instructions, wraps modulo 2^CNTSize

## Operation
- Accept on in_valid && in_ready; all in_* fields latched into internal registers that same edge; outputs then driven only from latched copies.
- States: IDLE, READ, EXEC, WB.
- IDLE: in_ready=1, all controls 0. Accept with in_kind=0 -> READ; with in_kind=1 -> WB.
- READ (1 cycle): Read=1, Read_ADDR_1=rs1, Read_ADDR_2=rs2, OP=op. -> EXEC.
- EXEC (1 cycle): Read=1, addresses and OP held; Overflow sampled at end of cycle into ovf latch and ovf_sticky. -> WB.
- WB (1 cycle): Write=1, Write_ADDR=rd; ALU op: S=1, Read/addresses/OP still held so ALU result is stable; LOAD: S=0, DIN=imm, Read=0. done=1, retired increments. -> IDLE.
- Controls (Write, Read, S) are 0 in every state not listed above; address/OP/DIN outputs hold last latched value between instructions.
- No back-to-back acceptance: in_ready drops the cycle after accept and returns in the cycle after WB.
- in_valid while not ready is ignored (no capture, no error); driver must hold fields stable until accepted.
- rd=0 is not special; it is written like any register.

## Timing
- Reset (rst high at edge): state=IDLE, in_ready=1, Write=Read=S=0, all addresses=0, OP=0, DIN=0, done=0, ovf_sticky=0, retired=0. Reset mid-instruction aborts it: no Write issued, no count.
- ALU op: accept edge T -> READ in T+1 -> EXEC in T+2 -> WB/done in T+3 -> in_ready high in T+4. 4-cycle throughput.
- LOAD: accept edge T -> WB/done in T+1 -> in_ready high in T+2. 2-cycle throughput.
- retired and done update in the same edge that leaves WB; retired 2^CNTSize-1 + 1 = 0.
- Overflow sampled only in EXEC; values in other cycles ignored.

## Configuration
- Macro SEQ_OVF_TRAP_EN.
- Defined: an ALU op whose sampled Overflow=1 has Write forced 0 in WB (destination unchanged); done still pulses, retired still counts; an extra output port ovf_trap pulses 1 in that WB cycle.
- Undefined: overflowing results are written back normally; ovf_trap port absent; ovf_sticky is the only overflow indication.

## Test plan
- Reset: hold rst 2 cycles mid-READ -> all outputs at reset values, no Write pulse, retired=0, in_ready=1 next cycle.
- LOAD rd=3 imm=0xDEADBEEF -> exactly one cycle with Write=1, S=0, Write_ADDR=3, DIN=0xDEADBEEF, done=1 at T+1; retired=1.
- ALU op rs1=3 rs2=4 rd=5 OP=add with no overflow -> Read=1 at T+1..T+3, Write=1 S=1 Write_ADDR=5 only at T+3, in_ready high T+4.
- ALU op with Overflow=1 during EXEC -> ovf_sticky=1 and stays 1 across subsequent clean ops; with SEQ_OVF_TRAP_EN Write=0 and ovf_trap=1 in WB, without it Write=1.
- in_valid held high continuously with 10 mixed instructions -> each accepted only when in_ready=1, no dropped/duplicated captures, retired=10.
- Counter wrap with CNTSize=4 -> 17 LOADs leave retired=1.
